// File: rtl/onehot_req_arbiter_if.sv
// Bundle between the request/acknowledge side and the one-hot arbiter.
// Carries the requests, the acknowledge, the one-hot grant lines and the status outputs.
interface onehot_req_arbiter_if;
    // Handshake: a grant is offered while valid=1 with exactly one y line high.
    // It is taken on a clk edge where valid=1 and ack=1. ack is ignored while valid=0.
    // A grant that waits too long for ack is withdrawn, and tmo pulses for one cycle.
    logic [7:0] req;
    logic       ack;
    logic       y7;
    logic       y6;
    logic       y5;
    logic       y4;
    logic       y3;
    logic       y2;
    logic       y1;
    logic       y0;
    logic       valid;
    logic [7:0] pending;
    logic       tmo;
    logic       fsm_state;

    modport master (
        output req, ack,
        input  y7, y6, y5, y4, y3, y2, y1, y0, valid, pending, tmo, fsm_state
    );

    modport slave (
        input  req, ack,
        output y7, y6, y5, y4, y3, y2, y1, y0, valid, pending, tmo, fsm_state
    );
endinterface

// File: rtl/onehot_req_arbiter.sv
// Captures rising edges on eight asynchronous request lines and serves them one at a time
// as a registered one-hot grant, using round-robin order and an acknowledge timeout.
module onehot_req_arbiter #(
    parameter int SYNC_STAGES = 2,   // 2..4
    parameter int TIMEOUT     = 255  // 1..255
) (
    input  logic clk,
    input  logic rst,
    onehot_req_arbiter_if.slave bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] sync_d;
    logic [7:0] rise;
    logic [7:0] pending;
    logic [7:0] clr;
    logic [7:0] y_q;
    logic       valid_q;
    logic       tmo_q;
    logic [0:0] state;
    logic [2:0] ptr;
    logic [7:0] cnt;
    logic [2:0] cand;
    logic [2:0] sel_idx;
    logic       sel_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            sync_d <= '0;
        end else begin
            sync_q[0] <= bus.req;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;
    // A new rise on the bit being acknowledged re-arms it: the set term is applied last.
    assign clr  = (state == S_GRANT && bus.ack) ? (8'd1 << ptr) : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
        end
    end

    // Round-robin search starts just after the last granted index and wraps back to it.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr;
        cand      = ptr;
        for (int k = 1; k <= 8; k++) begin
            cand = ptr + 3'(k);
            if (!sel_found && pending[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ptr     <= 3'd7;
            cnt     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        y_q     <= 8'd1 << sel_idx;
                        valid_q <= 1'b1;
                        ptr     <= sel_idx;
                        cnt     <= '0;
                        state   <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (bus.ack) begin
                        y_q     <= '0;
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        // Withdrawn without clearing pending, so the source is retried later.
                        y_q     <= '0;
                        valid_q <= 1'b0;
                        tmo_q   <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0} = y_q;
    assign bus.valid     = valid_q;
    assign bus.pending   = pending;
    assign bus.tmo       = tmo_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_onehot_req_arbiter.sv
// Bench for onehot_req_arbiter: table-driven vectors, hand-written corner sequences and
// randomized traffic compared every cycle against a behavioural model of the arbiter.
module tb_onehot_req_arbiter;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 4;
    localparam int NV      = 27;

    logic clk;
    logic rst;
    onehot_req_arbiter_if bus ();

    onehot_req_arbiter #(.SYNC_STAGES(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] y_vec;
    assign y_vec = {bus.y7, bus.y6, bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (bus.valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({name, "_wait_valid"}, 32'(bus.valid), 32'd1);
    endtask

    // ---------------- reference model ----------------
    // Requests travel down a delay line; an edge event is a 0->1 change at its far end.
    // Sources with outstanding events are served nearest-after-last-served first.
    logic [7:0] m_line[$];
    logic [7:0] m_last;
    bit         m_pend[8];
    int         m_gidx;     // granted source, -1 when nothing is offered
    int         m_rr;       // last source that received a grant
    int         m_shown;    // cycles the current grant has been visible
    bit         m_tmo;
    bit         s_ack;
    bit         s_rst;

    logic [7:0] ms_out;
    logic [7:0] ms_rise;
    bit         ms_new_tmo;

    always @(posedge clk) begin
        s_ack = bus.ack;
        s_rst = rst;
        if (rst) begin
            m_line.delete();
            for (int i = 0; i < SYNC; i++) m_line.push_back(8'h00);
            m_last = 8'h00;
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_gidx  = -1;
            m_rr    = 7;
            m_shown = 0;
            m_tmo   = 1'b0;
        end else begin
            ms_out  = m_line[SYNC-1];
            ms_rise = ms_out & ~m_last;
            m_last  = ms_out;
            m_line.push_front(bus.req);
            void'(m_line.pop_back());
            ms_new_tmo = 1'b0;
            if (m_gidx >= 0) begin
                if (bus.ack) begin
                    m_pend[m_gidx] = 1'b0;
                    m_gidx = -1;
                end else if (m_shown == TIMEOUT) begin
                    m_gidx = -1;
                    ms_new_tmo = 1'b1;
                end else begin
                    m_shown++;
                end
            end else begin
                for (int k = 1; k <= 8; k++) begin
                    if (m_pend[(m_rr + k) % 8]) begin
                        m_gidx  = (m_rr + k) % 8;
                        m_rr    = m_gidx;
                        m_shown = 1;
                        break;
                    end
                end
            end
            for (int i = 0; i < 8; i++) if (ms_rise[i]) m_pend[i] = 1'b1;
            m_tmo = ms_new_tmo;
        end
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] prev_y;
    logic       prev_valid = 1'b0;
    logic [7:0] e_y;
    logic [7:0] e_pend;

    always @(negedge clk) begin
        if (chk_en) begin
            e_y = (m_gidx >= 0) ? 8'(1 << m_gidx) : 8'h00;
            e_pend = '0;
            for (int i = 0; i < 8; i++) e_pend[i] = m_pend[i];
            exp_q.push_back(e_y);
            check("model_y", 32'(y_vec), 32'(exp_q.pop_front()));
            check("model_valid", 32'(bus.valid), 32'(m_gidx >= 0));
            check("model_pending", 32'(bus.pending), 32'(e_pend));
            check("model_tmo", 32'(bus.tmo), 32'(m_tmo));
            check("onehot0_y", 32'($onehot0(y_vec)), 32'd1);
            check("valid_eq_or_y", 32'(bus.valid), 32'(|y_vec));
            if (prev_valid && !s_ack && !s_rst && bus.valid)
                check("y_stable", 32'(y_vec), 32'(prev_y));
        end
        prev_valid = bus.valid;
        prev_y     = y_vec;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ack;
        logic [7:0] y;
        logic       valid;
        logic [7:0] pend;
        logic       tmo;
    } vec_t;

    vec_t tbl[NV];

    function automatic vec_t mk(input logic r, input logic [7:0] q, input logic a,
                                input logic [7:0] y, input logic v, input logic [7:0] p,
                                input logic t);
        vec_t e;
        e.rst = r; e.req = q; e.ack = a; e.y = y; e.valid = v; e.pend = p; e.tmo = t;
        return e;
    endfunction

    initial begin
        // reset with all requests high, then release and watch the synchroniser delay
        tbl[0]  = mk(1, 8'hFF, 0, 8'h00, 0, 8'h00, 0);
        tbl[1]  = mk(1, 8'hFF, 0, 8'h00, 0, 8'h00, 0);
        tbl[2]  = mk(0, 8'hFF, 0, 8'h00, 0, 8'h00, 0);
        tbl[3]  = mk(0, 8'hFF, 0, 8'h00, 0, 8'h00, 0);
        tbl[4]  = mk(0, 8'hFF, 0, 8'h00, 0, 8'hFF, 0);
        tbl[5]  = mk(0, 8'hFF, 0, 8'h01, 1, 8'hFF, 0);
        tbl[6]  = mk(1, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        tbl[7]  = mk(1, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        tbl[8]  = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        // single request on bit 5, acked the cycle the grant is visible
        tbl[9]  = mk(0, 8'h20, 0, 8'h00, 0, 8'h00, 0);
        tbl[10] = mk(0, 8'h20, 0, 8'h00, 0, 8'h00, 0);
        tbl[11] = mk(0, 8'h20, 0, 8'h00, 0, 8'h20, 0);
        tbl[12] = mk(0, 8'h20, 0, 8'h20, 1, 8'h20, 0);
        tbl[13] = mk(0, 8'h20, 1, 8'h00, 0, 8'h00, 0);
        tbl[14] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        tbl[15] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        // timeout on bit 2: four valid cycles, tmo pulse, one idle cycle, re-grant
        tbl[16] = mk(0, 8'h04, 0, 8'h00, 0, 8'h00, 0);
        tbl[17] = mk(0, 8'h04, 0, 8'h00, 0, 8'h00, 0);
        tbl[18] = mk(0, 8'h04, 0, 8'h00, 0, 8'h04, 0);
        tbl[19] = mk(0, 8'h04, 0, 8'h04, 1, 8'h04, 0);
        tbl[20] = mk(0, 8'h04, 0, 8'h04, 1, 8'h04, 0);
        tbl[21] = mk(0, 8'h04, 0, 8'h04, 1, 8'h04, 0);
        tbl[22] = mk(0, 8'h04, 0, 8'h04, 1, 8'h04, 0);
        tbl[23] = mk(0, 8'h04, 0, 8'h00, 0, 8'h04, 1);
        tbl[24] = mk(0, 8'h04, 0, 8'h04, 1, 8'h04, 0);
        tbl[25] = mk(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
        tbl[26] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);

        rst = 1'b1;
        bus.req = 8'h00;
        bus.ack = 1'b0;

        for (int i = 0; i < NV; i++) begin
            rst     = tbl[i].rst;
            bus.req = tbl[i].req;
            bus.ack = tbl[i].ack;
            tick();
            chk_en = 1'b1;
            check($sformatf("row%0d_y", i), 32'(y_vec), 32'(tbl[i].y));
            check($sformatf("row%0d_valid", i), 32'(bus.valid), 32'(tbl[i].valid));
            check($sformatf("row%0d_pending", i), 32'(bus.pending), 32'(tbl[i].pend));
            check($sformatf("row%0d_tmo", i), 32'(bus.tmo), 32'(tbl[i].tmo));
        end

        // round robin from ptr=7: bits 0,4,7 in order with one idle cycle between grants
        rst = 1'b1; tick(); rst = 1'b0; tick();
        bus.req = 8'h91;
        wait_valid("rr_first", 10);
        check("rr_first_y", 32'(y_vec), 32'h01);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check("rr_idle1_valid", 32'(bus.valid), 32'd0);
        check("rr_idle1_pending", 32'(bus.pending), 32'h90);
        tick();
        check("rr_second_y", 32'(y_vec), 32'h10);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check("rr_idle2_valid", 32'(bus.valid), 32'd0);
        tick();
        check("rr_third_y", 32'(y_vec), 32'h80);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check("rr_done_pending", 32'(bus.pending), 32'h00);
        bus.req = 8'h00;
        repeat (4) tick();
        bus.req = 8'h81;
        wait_valid("rr_again", 10);
        check("rr_again_first_y", 32'(y_vec), 32'h01);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check("rr_again_idle", 32'(bus.valid), 32'd0);
        tick();
        check("rr_again_second_y", 32'(y_vec), 32'h80);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        bus.req = 8'h00;
        repeat (3) tick();

        // collision: a fresh rise on bit 3 lands in the same cycle as its ack
        bus.req = 8'h08; tick(); bus.req = 8'h00;
        wait_valid("coll", 10);
        check("coll_grant_y", 32'(y_vec), 32'h08);
        bus.req = 8'h08;
        tick();
        tick();
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        bus.req = 8'h00;
        check("coll_ack_valid", 32'(bus.valid), 32'd0);
        check("coll_ack_pending", 32'(bus.pending), 32'h08);
        check("coll_ack_tmo", 32'(bus.tmo), 32'd0);
        tick();
        check("coll_regrant_y", 32'(y_vec), 32'h08);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check("coll_final_pending", 32'(bus.pending), 32'h00);
        repeat (2) tick();

        // reset in the middle of a grant drops it and all pending events
        bus.req = 8'h41; tick(); bus.req = 8'h00;
        wait_valid("mrst", 10);
        check("mrst_grant_y", 32'(y_vec), 32'h40);
        check("mrst_grant_pending", 32'(bus.pending), 32'h41);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_y", 32'(y_vec), 32'h00);
        check("mrst_valid", 32'(bus.valid), 32'd0);
        check("mrst_pending", 32'(bus.pending), 32'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("mrst_no_replay%0d", i), 32'(bus.valid), 32'd0);
        end

        // randomized traffic against the model
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom_range(0, 255));
            bus.ack = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        bus.ack = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
